// File: rtl/ch375_pkg.sv
// rtl/ch375_pkg.sv - shared addresses, states and status bits for the ch375 sequencer
package ch375_pkg;

  // ch375b register port addresses
  localparam logic [2:0] CHB_A_DATA  = 3'd0;  // write: command frame, read: received byte
  localparam logic [2:0] CHB_A_RXNEW = 3'd1;  // read: rx_new flag, write: clear rx_new
  localparam logic [2:0] CHB_A_TX    = 3'd2;  // write: data frame, read: tx idle
  localparam logic [2:0] CHB_A_INT   = 3'd3;  // read: INT# level

  // ch375_seq CPU register addresses
  localparam logic [2:0] SEQ_A_CMD   = 3'd0;
  localparam logic [2:0] SEQ_A_PARAM = 3'd1;
  localparam logic [2:0] SEQ_A_CTRL  = 3'd2;
  localparam logic [2:0] SEQ_A_RX    = 3'd3;
  localparam logic [2:0] SEQ_A_LEVEL = 3'd4;

  // Control byte fields (bit positions inside the byte lane)
  localparam int CTRL_START    = 0;
  localparam int CTRL_WAIT_INT = 1;

  // Status nibble bit positions
  localparam int ST_ERR     = 0;
  localparam int ST_TIMEOUT = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_BUSY    = 3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_SETTLE,
    S_TXW,
    S_PARAM,
    S_INTW,
    S_RX,
    S_RXRD,
    S_RXCLR,
    S_FIN
  } seq_state_e;

  // Place a byte in the [31:24] lane used by both register ports
  function automatic logic [31:0] byte_word(input logic [7:0] b);
    return {b, 24'h0};
  endfunction

endpackage

// File: rtl/ch375_fifo.sv
// rtl/ch375_fifo.sv - synchronous byte FIFO with flush, level and combinational head
module ch375_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic          push_ok, pop_ok;

  // Pushes into a full FIFO and pops from an empty one are dropped
  assign push_ok = push && (cnt_q != LW'(DEPTH));
  assign pop_ok  = pop && (cnt_q != '0);

  // Next pointers, count and storage; flush wins over everything
  always_comb begin
    wr_d  = wr_q + AW'(push_ok);
    rd_d  = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + LW'(push_ok) - LW'(pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = push_data;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: head is gated by the count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = (cnt_q == '0) ? 8'h00 : mem_q[rd_q];
  assign level = cnt_q;

endmodule

// File: rtl/ch375_seq.sv
// rtl/ch375_seq.sv - command sequencer driving the ch375b register port
module ch375_seq
  import ch375_pkg::*;
#(
  parameter int PARAM_DEPTH    = 4,
  parameter int RX_DEPTH       = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  a,
  input  logic [31:0] d,
  input  logic        we,
  output logic [31:0] spo,
  output logic        irq,
  output logic [2:0]  u_a,
  output logic [31:0] u_d,
  output logic        u_we,
  input  logic [31:0] u_spo
);

  localparam int PLW = $clog2(PARAM_DEPTH) + 1;
  localparam int RLW = $clog2(RX_DEPTH) + 1;

  seq_state_e  state_q, state_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        done_q, done_d, timeout_q, timeout_d, err_q, err_d;
  logic        wait_int_q, wait_int_d;
  logic [3:0]  rx_rem_q, rx_rem_d;
  logic [31:0] tmo_q, tmo_d;
  logic        irq_q, irq_d, u_we_q, u_we_d;
  logic [2:0]  u_a_q, u_a_d;
  logic [31:0] u_d_q, u_d_d;

  logic           p_push, p_pop, p_flush, r_push, r_pop, r_flush;
  logic [7:0]     p_head, r_head, cpu_byte;
  logic [PLW-1:0] p_level;
  logic [RLW-1:0] r_level;
  logic           busy, p_full, p_empty, waiting, cmd_write;
  logic [3:0]     status;
  logic           unused_bits;

  assign cpu_byte    = d[31:24];
  assign unused_bits = ^{d[23:0], u_spo[23:0]};
  assign busy        = (state_q != S_IDLE);
  assign p_full      = (p_level == PLW'(PARAM_DEPTH));
  assign p_empty     = (p_level == '0);
  assign r_pop       = we && (a == SEQ_A_RX);
  assign waiting     = (state_q == S_CMD) || (state_q == S_TXW) ||
                       (state_q == S_INTW) || (state_q == S_RX);

  ch375_fifo #(.DEPTH(PARAM_DEPTH), .LW(PLW)) u_param_fifo (
    .clk(clk), .rst_n(rst_n), .flush(p_flush), .push(p_push), .push_data(cpu_byte),
    .pop(p_pop), .head(p_head), .level(p_level)
  );

  ch375_fifo #(.DEPTH(RX_DEPTH), .LW(RLW)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .flush(r_flush), .push(r_push), .push_data(u_spo[31:24]),
    .pop(r_pop), .head(r_head), .level(r_level)
  );

  // CPU register writes, sequencer next state, timeout and next port outputs
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    err_d      = err_q;
    wait_int_d = wait_int_q;
    rx_rem_d   = rx_rem_q;
    tmo_d      = 32'd0;
    irq_d      = 1'b0;
    u_we_d     = 1'b0;
    u_a_d      = CHB_A_TX;
    u_d_d      = u_d_q;
    p_push     = 1'b0;
    p_pop      = 1'b0;
    p_flush    = 1'b0;
    r_push     = 1'b0;
    r_flush    = 1'b0;
    cmd_write  = 1'b0;

    if (we) begin
      case (a)
        SEQ_A_CMD: begin
          if (busy) err_d = 1'b1;
          else      cmd_d = cpu_byte;
        end
        SEQ_A_PARAM: begin
          if (busy || p_full) err_d  = 1'b1;
          else                p_push = 1'b1;
        end
        SEQ_A_CTRL: begin
          if (busy) begin
            err_d = 1'b1;
          end else if (cpu_byte[CTRL_START]) begin
            done_d     = 1'b0;
            timeout_d  = 1'b0;
            err_d      = 1'b0;
            r_flush    = 1'b1;
            wait_int_d = cpu_byte[CTRL_WAIT_INT];
            rx_rem_d   = (cpu_byte[7:4] > 4'(RX_DEPTH)) ? 4'(RX_DEPTH) : cpu_byte[7:4];
            state_d    = S_CMD;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_CMD: begin
        if (u_spo[24]) begin
          cmd_write = 1'b1;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_TXW;
      S_TXW: begin
        if (u_spo[24]) begin
          if (!p_empty)            state_d = S_PARAM;
          else if (wait_int_q)     state_d = S_INTW;
          else if (rx_rem_q != 0)  state_d = S_RX;
          else                     state_d = S_FIN;
        end
      end
      S_PARAM: begin
        p_pop   = 1'b1;
        state_d = S_SETTLE;
      end
      S_INTW: begin
        if (!u_spo[24]) state_d = (rx_rem_q != 0) ? S_RX : S_FIN;
      end
      S_RX: begin
        if (u_spo[24]) state_d = S_RXRD;
      end
      S_RXRD: begin
        r_push  = 1'b1;
        state_d = S_RXCLR;
      end
      S_RXCLR: begin
        rx_rem_d = rx_rem_q - 4'd1;
        state_d  = (rx_rem_q > 4'd1) ? S_RX : S_FIN;
      end
      S_FIN: begin
        done_d  = 1'b1;
        p_flush = 1'b1;
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (waiting && (state_d == state_q)) begin
      if (tmo_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        state_d   = S_FIN;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end

    // The port is registered, so it is set up for the state being entered.
    // The command write depends on the tx-idle read, so it lands one cycle later.
    case (state_d)
      S_INTW:  u_a_d = CHB_A_INT;
      S_RX:    u_a_d = CHB_A_RXNEW;
      S_RXRD:  u_a_d = CHB_A_DATA;
      S_RXCLR: begin
        u_a_d  = CHB_A_RXNEW;
        u_we_d = 1'b1;
      end
      S_PARAM: begin
        u_a_d  = CHB_A_TX;
        u_we_d = 1'b1;
        u_d_d  = byte_word(p_head);
      end
      default: u_a_d = CHB_A_TX;
    endcase
    if (cmd_write) begin
      u_a_d  = CHB_A_DATA;
      u_we_d = 1'b1;
      u_d_d  = byte_word(cmd_q);
    end
  end

  // State, flags and registered port outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_q      <= 1'b0;
      wait_int_q <= 1'b0;
      rx_rem_q   <= 4'd0;
      tmo_q      <= 32'd0;
      irq_q      <= 1'b0;
      u_we_q     <= 1'b0;
      u_a_q      <= CHB_A_TX;
      u_d_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      err_q      <= err_d;
      wait_int_q <= wait_int_d;
      rx_rem_q   <= rx_rem_d;
      tmo_q      <= tmo_d;
      irq_q      <= irq_d;
      u_we_q     <= u_we_d;
      u_a_q      <= u_a_d;
      u_d_q      <= u_d_d;
    end
  end

  // CPU read mux
  always_comb begin
    status           = 4'd0;
    status[ST_BUSY]    = busy;
    status[ST_DONE]    = done_q;
    status[ST_TIMEOUT] = timeout_q;
    status[ST_ERR]     = err_q;
    spo = 32'd0;
    case (a)
      SEQ_A_CMD:   spo = byte_word(cmd_q);
      SEQ_A_CTRL:  spo = byte_word({4'd0, status});
      SEQ_A_RX:    spo = byte_word(r_head);
      SEQ_A_LEVEL: spo = byte_word(8'(r_level));
      default:     spo = 32'd0;
    endcase
  end

  assign irq  = irq_q;
  assign u_we = u_we_q;
  assign u_a  = u_a_q;
  assign u_d  = u_d_q;

endmodule

// File: tb/tb_ch375_seq.sv
// tb/tb_ch375_seq.sv - directed self-checking bench for ch375_seq with a behavioural ch375b
module tb_ch375_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  a = 3'd0;
  logic [31:0] d = 32'd0;
  logic        we = 1'b0;
  logic [31:0] spo;
  logic        irq;
  logic [2:0]  u_a;
  logic [31:0] u_d;
  logic        u_we;
  logic [31:0] u_spo;

  int n_checks = 0;
  int n_errors = 0;

  // ch375b model state
  logic        tx_idle = 1'b1;
  int          tx_cnt = 0;
  logic        rx_new = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        int_n = 1'b1;
  logic [7:0]  replies[$];
  logic [8:0]  frames[$];
  int          cyc = 0, irq_cnt = 0, irq_cyc = 0, idle_cyc = 0, early = 0;
  bit          int_test = 1'b0;

  ch375_seq #(.PARAM_DEPTH(4), .RX_DEPTH(8), .TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .spo(spo), .irq(irq),
    .u_a(u_a), .u_d(u_d), .u_we(u_we), .u_spo(u_spo)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (u_a)
      3'd0:    u_spo = {rx_byte, 24'h0};
      3'd1:    u_spo = {7'd0, rx_new, 24'h0};
      3'd2:    u_spo = {7'd0, tx_idle, 24'h0};
      3'd3:    u_spo = {7'd0, int_n, 24'h0};
      default: u_spo = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    cyc++;
    if (irq) begin
      irq_cnt++;
      irq_cyc = cyc;
    end
    if (u_we && (u_a == 3'd0 || u_a == 3'd2)) begin
      frames.push_back({u_a == 3'd0, u_d[31:24]});
      tx_idle <= 1'b0;
      tx_cnt  <= 20;
    end else if (!tx_idle) begin
      if (tx_cnt == 1) begin
        tx_idle <= 1'b1;
        idle_cyc = cyc;
      end
      tx_cnt <= tx_cnt - 1;
    end
    if (u_we && u_a == 3'd1) rx_new <= 1'b0;
    else if (!rx_new && replies.size() > 0) begin
      rx_new  <= 1'b1;
      rx_byte <= replies.pop_front();
    end
    if (int_test && int_n && u_a == 3'd1) early++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frame_at(input int i);
    return (frames.size() > i) ? 32'(frames[i]) : 32'hDEAD;
  endfunction

  task automatic cpu_wr(input logic [2:0] addr, input logic [7:0] b);
    @(negedge clk);
    a  = addr;
    d  = {b, 24'h0};
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    d  = 32'd0;
  endtask

  task automatic rd_check(input string tag, input logic [2:0] addr, input logic [7:0] exp);
    @(negedge clk);
    a = addr;
    #1;
    check(tag, {24'd0, spo[31:24]}, {24'd0, exp});
  endtask

  task automatic wait_irq(input string tag, input int max);
    bit seen = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (irq) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, el;
    bit hit;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_u_we", 32'(u_we), 32'd0);
    check("rst_u_a", 32'(u_a), 32'd2);
    check("rst_u_d", u_d, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    a = 3'd2; #1;
    check("rst_status", spo, 32'd0);
    a = 3'd4; #1;
    check("rst_level", spo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Command only
    cpu_wr(3'd0, 8'h06);
    frames.delete();
    ic = irq_cnt;
    cpu_wr(3'd2, 8'h01);
    wait_irq("t1_irq", 200);
    repeat (3) @(negedge clk);
    check("t1_irq_cnt", 32'(irq_cnt - ic), 32'd1);
    check("t1_nframes", 32'(frames.size()), 32'd1);
    check("t1_frame0", frame_at(0), 32'h106);
    rd_check("t1_status", 3'd2, 8'h04);

    // Command with one param and one response byte
    cpu_wr(3'd1, 8'h57);
    replies.push_back(8'hA8);
    frames.delete();
    cpu_wr(3'd2, 8'h11);
    wait_irq("t2_irq", 300);
    check("t2_nframes", 32'(frames.size()), 32'd2);
    check("t2_frame0", frame_at(0), 32'h106);
    check("t2_frame1", frame_at(1), 32'h057);
    rd_check("t2_level", 3'd4, 8'd1);
    rd_check("t2_head", 3'd3, 8'hA8);
    cpu_wr(3'd3, 8'h00);
    rd_check("t2_level_pop", 3'd4, 8'd0);
    rd_check("t2_status", 3'd2, 8'h04);

    // Wait for INT#, two response bytes
    int_n = 1'b1;
    replies.push_back(8'h14);
    replies.push_back(8'h00);
    early = 0;
    int_test = 1'b1;
    cpu_wr(3'd2, 8'h23);
    repeat (500) @(negedge clk);
    rd_check("t3_busy_before_int", 3'd2, 8'h08);
    int_n = 1'b0;
    wait_irq("t3_irq", 300);
    int_test = 1'b0;
    int_n = 1'b1;
    check("t3_early_rx", 32'(early), 32'd0);
    rd_check("t3_level", 3'd4, 8'd2);
    rd_check("t3_head0", 3'd3, 8'h14);
    cpu_wr(3'd3, 8'h00);
    rd_check("t3_head1", 3'd3, 8'h00);
    cpu_wr(3'd3, 8'h00);
    rd_check("t3_level_end", 3'd4, 8'd0);

    // Param overflow, then a busy write to cmd
    for (int i = 0; i < 5; i++) cpu_wr(3'd1, 8'hA1 + 8'(i));
    rd_check("t4_err_overflow", 3'd2, 8'h05);
    cpu_wr(3'd0, 8'h12);
    frames.delete();
    cpu_wr(3'd2, 8'h01);
    cpu_wr(3'd0, 8'h99);
    wait_irq("t4_irq", 400);
    check("t4_nframes", 32'(frames.size()), 32'd5);
    check("t4_frame0", frame_at(0), 32'h112);
    for (int i = 0; i < 4; i++) check("t4_param", frame_at(i + 1), 32'h0A1 + 32'(i));
    rd_check("t4_cmd_reg", 3'd0, 8'h12);
    rd_check("t4_status", 3'd2, 8'h05);

    // rx_count 15 is clamped to RX_DEPTH (8)
    for (int i = 0; i < 8; i++) replies.push_back(8'h30 + 8'(i));
    cpu_wr(3'd2, 8'hF1);
    wait_irq("t5_irq", 600);
    rd_check("t5_level", 3'd4, 8'd8);
    rd_check("t5_head", 3'd3, 8'h30);
    rd_check("t5_status", 3'd2, 8'h04);
    check("t5_replies_left", 32'(replies.size()), 32'd0);

    // Timeout with a silent model; start also flushes the full rx FIFO
    ic = irq_cnt;
    cpu_wr(3'd2, 8'h11);
    wait_irq("t6_irq", 1500);
    repeat (3) @(negedge clk);
    check("t6_irq_cnt", 32'(irq_cnt - ic), 32'd1);
    el = irq_cyc - idle_cyc;
    check("t6_latency_ok", 32'(el >= 1000 && el <= 1010), 32'd1);
    rd_check("t6_status", 3'd2, 8'h06);
    rd_check("t6_level", 3'd4, 8'd0);

    // Reset during PARAM, then a normal run
    cpu_wr(3'd1, 8'hB1);
    cpu_wr(3'd1, 8'hB2);
    cpu_wr(3'd1, 8'hB3);
    cpu_wr(3'd2, 8'h01);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (u_we && u_a == 3'd2) begin
        hit = 1'b1;
        break;
      end
    end
    check("t7_param_seen", 32'(hit), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t7_u_we", 32'(u_we), 32'd0);
    a = 3'd2; #1;
    check("t7_status", spo, 32'd0);
    a = 3'd4; #1;
    check("t7_level", spo, 32'd0);
    frames.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cpu_wr(3'd0, 8'h06);
    cpu_wr(3'd2, 8'h01);
    wait_irq("t7_irq", 300);
    check("t7_nframes", 32'(frames.size()), 32'd1);
    check("t7_frame0", frame_at(0), 32'h106);
    rd_check("t7_status_end", 3'd2, 8'h04);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
